// File: rtl/serpent_inv_linear_transform.sv
// Pipelined inverse Serpent linear transform; the state is transformed only on tag APPLY_ROUND, otherwise bypassed.
// Define SERPENT_INVLT_ONE_STAGE_EN to fold both stages into a single register (latency 1, capacity 1).
module serpent_inv_linear_transform #(
  parameter logic [5:0] APPLY_ROUND = 6'd32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_data,
  input  logic [5:0]   i_round,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_data,
  output logic [5:0]   o_round
);

  function automatic logic [127:0] f_stage1(input logic [127:0] d);
    logic [31:0] x0, x1, x2, x3;
    {x0, x1, x2, x3} = d;
    x2 = {x2[21:0], x2[31:22]};
    x0 = {x0[4:0], x0[31:5]};
    x2 = x2 ^ x3 ^ {x1[24:0], 7'd0};
    x0 = x0 ^ x1 ^ x3;
    x3 = {x3[6:0], x3[31:7]};
    x1 = {x1[0], x1[31:1]};
    return {x0, x1, x2, x3};
  endfunction

  function automatic logic [127:0] f_stage2(input logic [127:0] d);
    logic [31:0] x0, x1, x2, x3;
    {x0, x1, x2, x3} = d;
    x3 = x3 ^ x2 ^ {x0[28:0], 3'd0};
    x1 = x1 ^ x0 ^ x2;
    x2 = {x2[2:0], x2[31:3]};
    x0 = {x0[12:0], x0[31:13]};
    return {x0, x1, x2, x3};
  endfunction

  logic         r_o_valid;
  logic [127:0] r_o_data;
  logic [5:0]   r_o_round;
  logic         w_s2_load;

  assign w_s2_load = !r_o_valid || i_ready;

`ifdef SERPENT_INVLT_ONE_STAGE_EN
  logic w_apply;

  assign w_apply = (i_round == APPLY_ROUND);
  assign o_ready = w_s2_load;

  // Output stage: whole inverse sequence evaluated from the input beat
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_o_valid <= 1'b0;
      r_o_data  <= 128'd0;
      r_o_round <= 6'd0;
    end else if (w_s2_load) begin
      r_o_valid <= i_valid;
      if (i_valid) begin
        r_o_data  <= w_apply ? f_stage2(f_stage1(i_data)) : i_data;
        r_o_round <= i_round;
      end
    end
  end
`else
  logic         r_s1_valid;
  logic         r_s1_apply;
  logic [127:0] r_s1_data;
  logic [5:0]   r_s1_round;
  logic         w_s1_load;

  // s1 may refill while s2 drains on the same edge, so a full pipe still streams
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign o_ready   = w_s1_load;

  // First stage: apply decision is latched here alongside the tag
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_apply <= 1'b0;
      r_s1_data  <= 128'd0;
      r_s1_round <= 6'd0;
    end else if (w_s1_load) begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_apply <= (i_round == APPLY_ROUND);
        r_s1_data  <= (i_round == APPLY_ROUND) ? f_stage1(i_data) : i_data;
        r_s1_round <= i_round;
      end
    end
  end

  // Second stage: drives the output register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_o_valid <= 1'b0;
      r_o_data  <= 128'd0;
      r_o_round <= 6'd0;
    end else if (w_s2_load) begin
      r_o_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_o_data  <= r_s1_apply ? f_stage2(r_s1_data) : r_s1_data;
        r_o_round <= r_s1_round;
      end
    end
  end
`endif

  assign o_valid = r_o_valid;
  assign o_data  = r_o_data;
  assign o_round = r_o_round;

endmodule

// File: tb/tb_serpent_inv_linear_transform.sv
// Randomized bench: every output is checked by applying the forward Serpent LT and matching the accepted input.
module tb_serpent_inv_linear_transform;

`ifdef SERPENT_INVLT_ONE_STAGE_EN
  localparam int LAT = 1;
  localparam int CAP = 1;
`else
  localparam int LAT = 2;
  localparam int CAP = 2;
`endif
  localparam logic [5:0] APPLY = 6'd32;

  logic         clk;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] i_data;
  logic [5:0]   i_round;
  logic         o_valid;
  logic         i_ready;
  logic [127:0] o_data;
  logic [5:0]   o_round;

  serpent_inv_linear_transform dut (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_round (i_round),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_round (o_round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [5:0]   r;
    int           c;
  } beat_t;

  beat_t        sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           n_acc   = 0;
  bit           lat_mode = 1'b0;
  bit           held     = 1'b0;
  logic [127:0] held_data;
  logic [5:0]   held_round;
  logic [127:0] last_data;
  logic [5:0]   last_round;

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Forward Serpent linear transform (the reference the inverse must undo)
  function automatic logic [127:0] fwd_lt(input logic [127:0] d);
    logic [31:0] x0, x1, x2, x3;
    {x0, x1, x2, x3} = d;
    x0 = rol(x0, 13);
    x2 = rol(x2, 3);
    x1 = x1 ^ x0 ^ x2;
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rol(x1, 1);
    x3 = rol(x3, 7);
    x0 = x0 ^ x1 ^ x3;
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rol(x0, 5);
    x2 = rol(x2, 22);
    return {x0, x1, x2, x3};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: sample settled handshakes, score outputs, record accepted inputs
  task automatic tick();
    beat_t e;
    #1;
    if (i_rst_n) begin
      if (held) begin
        chk("hold_valid", {127'd0, o_valid}, 128'd1);
        chk("hold_data", o_data, held_data);
        chk("hold_round", {122'd0, o_round}, {122'd0, held_round});
      end
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 128'd1, 128'd0);
        end else begin
          e = sb.pop_front();
          if (e.r == APPLY) chk("lt_roundtrip", fwd_lt(o_data), e.d);
          else              chk("bypass_data", o_data, e.d);
          chk("round_tag", {122'd0, o_round}, {122'd0, e.r});
          if (lat_mode) chk("latency", 128'(cyc - e.c), 128'(LAT));
          last_data  = o_data;
          last_round = o_round;
        end
      end
      held       = o_valid && !i_ready;
      held_data  = o_data;
      held_round = o_round;
      if (i_valid && o_ready) begin
        sb.push_back('{i_data, i_round, cyc});
        n_acc++;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    if (sb.size() != 0) chk("drain_timeout", 128'(sb.size()), 128'd0);
  endtask

  task automatic send(input logic [127:0] d, input logic [5:0] r);
    int start;
    start   = n_acc;
    i_valid = 1'b1;
    i_data  = d;
    i_round = r;
    i_ready = 1'b1;
    for (int k = 0; k < 10 && n_acc == start; k++) tick();
    i_valid = 1'b0;
    if (n_acc == start) chk("accept_timeout", 128'd0, 128'd1);
    drain();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b1;
    i_ready = 1'b1;
    i_data  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    i_round = APPLY;

    // Reset held with valid input present
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_valid", {127'd0, o_valid}, 128'd0);
      chk("rst_data", o_data, 128'd0);
      chk("rst_round", {122'd0, o_round}, 128'd0);
    end
    i_rst_n = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    chk("rst_oready", {127'd0, o_ready}, 128'd1);

    // Directed vectors
    send(128'h00001000_00000000_20000000_00000080, APPLY);
    chk("vec_unit", last_data, 128'h00000000_00000000_00000000_00000001);
    send(128'd0, APPLY);
    chk("vec_zero", last_data, 128'd0);
    send(128'h0123456789ABCDEF_FEDCBA9876543210, 6'd5);
    chk("vec_bypass", last_data, 128'h0123456789ABCDEF_FEDCBA9876543210);
    chk("vec_bypass_round", {122'd0, last_round}, 128'd5);

    // Back-to-back 8 beats with exact latency
    begin
      int start;
      start    = n_acc;
      lat_mode = 1'b1;
      i_ready  = 1'b1;
      for (int k = 0; k < 8; k++) begin
        i_valid = 1'b1;
        i_data  = rnd128();
        i_round = (k == 3) ? 6'd7 : APPLY;
        tick();
      end
      chk("b2b_accepts", 128'(n_acc - start), 128'd8);
      drain();
      lat_mode = 1'b0;
    end

    // Downstream stall during streaming
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_data  = rnd128();
      i_round = APPLY;
      tick();
    end
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_data = rnd128();
      tick();
    end
    chk("full_oready", {127'd0, o_ready}, 128'd0);
    chk("full_occupancy", 128'(sb.size()), 128'(CAP));
    drain();

    // Reset in the middle of a stalled stream discards in-flight beats
    i_valid = 1'b1;
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_data = rnd128();
      tick();
    end
    i_rst_n = 1'b0;
    tick();
    sb.delete();
    held    = 1'b0;
    i_rst_n = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("midrst_valid", {127'd0, o_valid}, 128'd0);
    chk("midrst_oready", {127'd0, o_ready}, 128'd1);
    for (int k = 0; k < 4; k++) tick();

    // Random traffic
    begin
      int start;
      start = n_acc;
      for (int k = 0; k < 20000 && (n_acc - start) < 1000; k++) begin
        i_valid = ($urandom_range(3) != 0);
        i_ready = ($urandom_range(3) != 0);
        i_data  = rnd128();
        i_round = ($urandom_range(7) == 0) ? 6'($urandom_range(63)) : APPLY;
        tick();
      end
      chk("rand_accepts", 128'(n_acc - start), 128'd1000);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
